// File: rtl/dram_burst_sched_pkg.sv
// Shared types and constants for the DRAM burst scheduler and its datapath.
package dram_burst_sched_pkg;

  localparam int unsigned BurstLen = 8;
  localparam int unsigned CntW     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StClr,
    StTurn
  } sched_state_t;

  typedef enum logic {
    DirRd,
    DirWr
  } dir_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_dir remembers the most recent winner.
module rr_arb2
  import dram_burst_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic rd_req,
  input  logic wr_req,
  input  logic take,
  output logic pick_valid,
  output dir_t pick_dir
);

  dir_t last_dir_q;

  always_comb begin
    pick_valid = rd_req | wr_req;
    pick_dir   = DirRd;
    if (rd_req && wr_req) begin
      pick_dir = (last_dir_q == DirWr) ? DirRd : DirWr;
    end else if (wr_req) begin
      pick_dir = DirWr;
    end
  end

  // Reads win the first tie after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_dir_q <= DirWr;
    end else if (take && pick_valid) begin
      last_dir_q <= pick_dir;
    end
  end

endmodule

// File: rtl/dram_burst_sched.sv
// Read/write burst scheduler: grants one requester per burst, drives the datapath
// enables/clear/column/store word and inserts turnaround gaps on direction changes.
module dram_burst_sched
  import dram_burst_sched_pkg::*;
#(
  parameter int unsigned BURST    = BurstLen,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned COL_W    = 3,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cas_ok,
  input  logic              rd_req,
  input  logic [COL_W-1:0]  rd_col,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              dt_rd_en,
  output logic              dt_wr_en,
  output logic              dt_clear,
  output logic [COL_W-1:0]  dt_col,
  output logic [WORD_W-1:0] dt_memstore,
  input  logic [WORD_W-1:0] dt_memload
);

  localparam logic [CntW-1:0] LastCnt  = CntW'(BURST + 2);
  localparam logic [CntW-1:0] TurnLast = CntW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  sched_state_t      state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic              rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, clear_q, clear_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [WORD_W-1:0] store_q, store_d, rd_data_q, rd_data_d;

  logic take;
  logic pick_valid;
  dir_t pick_dir;

  rr_arb2 u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .take       (take),
    .pick_valid (pick_valid),
    .pick_dir   (pick_dir)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    rd_gnt_d   = 1'b0;
    wr_gnt_d   = 1'b0;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    clear_d    = 1'b0;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    col_d      = col_q;
    store_d    = store_q;
    rd_data_d  = rd_data_q;
    take       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cas_ok && pick_valid) begin
          take    = 1'b1;
          dir_d   = pick_dir;
          cnt_d   = '0;
          state_d = StXfer;
          if (pick_dir == DirRd) begin
            rd_gnt_d = 1'b1;
            rd_en_d  = 1'b1;
            col_d    = rd_col;
          end else begin
            wr_gnt_d = 1'b1;
            wr_en_d  = 1'b1;
            col_d    = wr_col;
            store_d  = wr_data;
          end
        end
      end
      StXfer: begin
        if (cnt_q == LastCnt) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          clear_d = 1'b1;
          state_d = StClr;
          if (dir_q == DirRd) begin
            rd_valid_d = 1'b1;
            rd_data_d  = dt_memload;
          end else begin
            wr_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClr: begin
        // Turn the bus around whenever the next winner runs the other way.
        if (pick_valid && (pick_dir != dir_q) && (TURN_CYC > 0)) begin
          state_d = StTurn;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      dir_q      <= DirWr;
      cnt_q      <= '0;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      clear_q    <= 1'b0;
      col_q      <= '0;
      store_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      clear_q    <= clear_d;
      col_q      <= col_d;
      store_q    <= store_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_gnt      = rd_gnt_q;
  assign wr_gnt      = wr_gnt_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;
  assign rd_data     = rd_data_q;
  assign dt_rd_en    = rd_en_q;
  assign dt_wr_en    = wr_en_q;
  assign dt_clear    = clear_q;
  assign dt_col      = col_q;
  assign dt_memstore = store_q;

endmodule
